// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl (with helper cell full_adder)
// Brief    : Bit-serial WIDTH-bit adder, one full_adder cell reused per clock.
// Revision : 1.0
// ============================================================================

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic CarryOut
);
  assign S        = A ^ B ^ Cin;
  assign CarryOut = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] S,
  output logic             CarryOut
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] acc_next;

  full_adder u_cell (
    .A        (op_a[0]),
    .B        (op_b[0]),
    .Cin      (carry),
    .S        (cell_s),
    .CarryOut (cell_co)
  );

  // Sum bits enter at the MSB so that after WIDTH steps the LSB sits at bit 0.
  assign acc_next = (acc >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      S        <= '0;
      CarryOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            op_a  <= A;
            op_b  <= B;
            carry <= Cin;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= acc_next;
          carry <= cell_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            S        <= acc_next;
            CarryOut <= cell_co;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
// Revision : 1.0
// ============================================================================
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, st8, cin8, busy8, done8, co8;
  logic [7:0] a8, b8, s8;
  logic       rst1, st1, cin1, busy1, done1, co1;
  logic [0:0] a1, b1, s1;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .Start(st8), .A(a8), .B(b8), .Cin(cin8),
    .Busy(busy8), .Done(done8), .S(s8), .CarryOut(co8)
  );
  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .Start(st1), .A(a1), .B(b1), .Cin(cin1),
    .Busy(busy1), .Done(done1), .S(s1), .CarryOut(co1)
  );

  typedef struct {
    logic [8:0] v;
    int         c;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t e8, e1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest expected result and its cycle.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) chk("done8_unexpected", {31'b0, done8}, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("sum8", {23'b0, co8, s8}, {23'b0, e8.v});
        chk("lat8", cyc, e8.c);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("done1_unexpected", {31'b0, done1}, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("sum1", {30'b0, co1, s1}, {23'b0, e1.v});
        chk("lat1", cyc, e1.c);
      end
    end
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input bit expect_done, input logic [8:0] expv, output int e0);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    e0  = cyc;
    if (expect_done) begin
      e.v = expv;
      e.c = e0 + 8;
      q8.push_back(e);
    end
  endtask

  task automatic go1(input logic a, input logic b, input logic c, input logic [8:0] expv);
    exp_t e;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    e.v = expv;
    e.c = cyc + 1;
    q1.push_back(e);
  endtask

  initial begin
    int   e0;
    int   nb;
    exp_t e;
    rst8 = 1'b1; st8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; st1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", {31'b0, busy8}, 32'd0);
    chk("rst_done8", {31'b0, done8}, 32'd0);
    chk("rst_s8",    {24'b0, s8},    32'd0);
    chk("rst_co8",   {31'b0, co8},   32'd0);
    chk("rst_busy1", {31'b0, busy1}, 32'd0);
    chk("rst_s1",    {31'b0, s1},    32'd0);
    chk("rst_co1",   {31'b0, co1},   32'd0);
    @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0;

    // Basic add and Busy duration
    go8(8'h5A, 8'h3C, 1'b0, 1'b1, 9'h096, e0);
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      nb += int'(busy8);
    end
    chk("busy_cycles", nb, 32'd8);

    // Carry-out cases; previous result must hold through the next RUN
    go8(8'hFF, 8'h01, 1'b0, 1'b1, 9'h100, e0);
    repeat (9) @(negedge clk);
    go8(8'hFF, 8'hFF, 1'b1, 1'b1, 9'h1FF, e0);
    repeat (4) @(negedge clk);
    chk("hold_s8",  {24'b0, s8},  32'h00);
    chk("hold_co8", {31'b0, co8}, 32'd1);
    repeat (5) @(negedge clk);

    // Start held high, operands changed mid-RUN
    @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1; st8 = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    e.v = 9'h034; e.c = e0 + 8;
    q8.push_back(e);
    repeat (3) @(negedge clk);
    a8 = 8'hAA; b8 = 8'h56;
    repeat (7) @(posedge clk); #1;
    chk("no_accept_in_done", {31'b0, busy8}, 32'd0);
    @(posedge clk); #1;
    chk("reaccept_busy", {31'b0, busy8}, 32'd1);
    e.v = 9'h101; e.c = e0 + 18;
    q8.push_back(e);
    st8 = 1'b0;
    repeat (10) @(negedge clk);

    // Reset during RUN aborts without Done
    go8(8'h12, 8'h34, 1'b0, 1'b0, 9'h000, e0);
    repeat (4) @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'b0, busy8}, 32'd0);
    chk("abort_done", {31'b0, done8}, 32'd0);
    chk("abort_s8",   {24'b0, s8},    32'd0);
    chk("abort_co8",  {31'b0, co8},   32'd0);
    @(negedge clk);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    go8(8'h12, 8'h34, 1'b0, 1'b1, 9'h046, e0);
    repeat (9) @(negedge clk);

    // Start coincident with reset
    @(negedge clk);
    st8 = 1'b1; rst8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(posedge clk); #1;
    chk("rst_start_busy", {31'b0, busy8}, 32'd0);
    chk("rst_start_s8",   {24'b0, s8},    32'd0);
    st8 = 1'b0; rst8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_start_idle", {31'b0, busy8}, 32'd0);

    // WIDTH=1 full-adder truth table
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kb;
      kb = 3'(k);
      go1(kb[2], kb[1], kb[0], 9'(kb[2]) + 9'(kb[1]) + 9'(kb[0]));
      repeat (2) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
